instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the instruction decoder. Holds the PC and issues word requests to instruction memory

---
 rtl/instruction_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem requests, 2-entry instruction queue toward decode.
// Redirect flushes the queue; an in-flight fetch is drained (its word is dropped when it returns).
module instruction_fetch_unit #(
  parameter int             bus      = 32,
  parameter logic [bus-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req,
  output logic [bus-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic           imem_rvalid,
  input  logic [31:0]    imem_rdata,
  input  logic           redirect,
  input  logic [bus-1:0] redirect_pc,
  output logic           instr_valid,
  output logic [31:0]    instr_out,
  output logic [bus-1:0] pc_out,
  input  logic           id_ready
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [bus-1:0] PC_STEP = bus'(4);

  logic [1:0]     state_q, state_d;
  logic [bus-1:0] pc_q, pc_d;
  logic [bus-1:0] req_pc_q, req_pc_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    e0_dat_q, e0_dat_d, e1_dat_q, e1_dat_d;
  logic [bus-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic           push, pop;

  // Request is gated by reset so nothing is issued during the reset cycle.
  assign imem_req    = rst_n && (state_q == S_FETCH) && (cnt_q < 2'd2) && !redirect;
  assign imem_addr   = pc_q;
  assign instr_valid = (cnt_q != 2'd0);
  assign instr_out   = e0_dat_q;
  assign pc_out      = e0_pc_q;
  assign pop         = instr_valid && id_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    cnt_d    = cnt_q;
    e0_dat_d = e0_dat_q;
    e0_pc_d  = e0_pc_q;
    e1_dat_d = e1_dat_q;
    e1_pc_d  = e1_pc_q;
    push     = 1'b0;

    if (redirect) begin
      pc_d    = {redirect_pc[bus-1:2], 2'b00};
      cnt_d   = 2'd0;
      state_d = (state_q == S_WAIT && !imem_rvalid) ? S_DRAIN : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            push    = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase

      // Entry 0 is always the head; a pop shifts entry 1 down.
      if (push && pop) begin
        if (cnt_q == 2'd1) begin
          e0_dat_d = imem_rdata;
          e0_pc_d  = req_pc_q;
        end else begin
          e0_dat_d = e1_dat_q;
          e0_pc_d  = e1_pc_q;
          e1_dat_d = imem_rdata;
          e1_pc_d  = req_pc_q;
        end
      end else if (push) begin
        if (cnt_q == 2'd0) begin
          e0_dat_d = imem_rdata;
          e0_pc_d  = req_pc_q;
        end else begin
          e1_dat_d = imem_rdata;
          e1_pc_d  = req_pc_q;
        end
        cnt_d = cnt_q + 2'd1;
      end else if (pop) begin
        e0_dat_d = e1_dat_q;
        e0_pc_d  = e1_pc_q;
        cnt_d    = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      cnt_q    <= 2'd0;
      e0_dat_q <= '0;
      e0_pc_q  <= '0;
      e1_dat_q <= '0;
      e1_pc_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
      e0_dat_q <= e0_dat_d;
      e0_pc_q  <= e0_pc_d;
      e1_dat_q <= e1_dat_d;
      e1_pc_q  <= e1_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, streaming, backpressure, redirect, PC wrap, reset mid-fetch.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        id_ready;

  instruction_fetch_unit #(.bus(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  // Memory responder: acks immediately, returns 0xA0000000+addr one cycle later.
  bit          auto_mem = 0;
  bit          pend_v   = 0;
  logic [31:0] pend_d   = '0;

  logic [31:0] log_pc[$];
  logic [31:0] log_dat[$];
  int          log_cyc[$];
  logic [31:0] ack_addr[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (auto_mem) begin
      imem_rvalid = pend_v;
      imem_rdata  = pend_d;
    end
    #1;
    if (auto_mem) begin
      imem_ack = imem_req;
      pend_v   = imem_req;
      pend_d   = 32'hA000_0000 + imem_addr;
    end
    if (imem_req && imem_ack) ack_addr.push_back(imem_addr);
    if (instr_valid && id_ready) begin
      log_pc.push_back(pc_out);
      log_dat.push_back(instr_out);
      log_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    log_pc.delete();
    log_dat.delete();
    log_cyc.delete();
    ack_addr.delete();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    auto_mem    = 0;
    pend_v      = 0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    cyc = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;

    // Reset
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("rst_valid2", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_req", {31'b0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    // Streaming
    clear_logs();
    cyc      = 0;
    auto_mem = 1;
    id_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("str_n", log_pc.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("str_pc", log_pc[i], 32'(4 * i));
      chk("str_dat", log_dat[i], 32'hA000_0000 + 32'(4 * i));
      chk("str_cyc", log_cyc[i], 32'(2 + 2 * i));
    end

    // Backpressure
    do_reset();
    auto_mem = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_valid", {31'b0, instr_valid}, 32'h1);
    chk("bp_pc_a", pc_out, 32'h0);
    tick();
    tick();
    chk("bp_req", {31'b0, imem_req}, 32'h0);
    chk("bp_acks", ack_addr.size(), 32'd2);
    chk("bp_pc_b", pc_out, 32'h0);
    chk("bp_dat_b", instr_out, 32'hA000_0000);
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_pop0", log_pc[0], 32'h0);
    chk("bp_pop1", log_pc[1], 32'h4);
    chk("bp_dat1", log_dat[1], 32'hA000_0004);
    chk("bp_resume", ack_addr[2], 32'h8);

    // Redirect while waiting on fetch of 0x8
    do_reset();
    auto_mem = 1;
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rd_ack8", ack_addr[2], 32'h8);
    auto_mem    = 0;
    pend_v      = 0;
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    clear_logs();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("rd_req_off", {31'b0, imem_req}, 32'h0);
    tick();
    redirect    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("rd_drain_req", {31'b0, imem_req}, 32'h0);
    chk("rd_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("rd_req", {31'b0, imem_req}, 32'h1);
    chk("rd_addr", imem_addr, 32'h100);
    chk("rd_valid2", {31'b0, instr_valid}, 32'h0);
    auto_mem = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("rd_n", log_pc.size(), 32'd1);
    chk("rd_pc", log_pc[0], 32'h100);
    chk("rd_dat", log_dat[0], 32'hA000_0100);

    // PC wrap
    do_reset();
    auto_mem    = 1;
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("wr_pc0", log_pc[0], 32'hFFFF_FFFC);
    chk("wr_dat0", log_dat[0], 32'h9FFF_FFFC);
    chk("wr_pc1", log_pc[1], 32'h0);
    chk("wr_dat1", log_dat[1], 32'hA000_0000);
    chk("wr_acks", ack_addr[1], 32'h0);

    // Reset during WAIT, word returns during and after reset
    do_reset();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    rst_n    = 1'b0;
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBADB_AD00;
    #1;
    chk("rw_req_rst", {31'b0, imem_req}, 32'h0);
    chk("rw_valid_rst", {31'b0, instr_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rw_req", {31'b0, imem_req}, 32'h1);
    chk("rw_addr", imem_addr, 32'h0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    chk("rw_valid", {31'b0, instr_valid}, 32'h0);
    chk("rw_req2", {31'b0, imem_req}, 32'h1);
    chk("rw_addr2", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
